// File: rtl/sdram_wr_sched_pkg.sv
// Shared types for the SDRAM write-side burst scheduler: FSM states and the
// burst-length field width helper.
package sdram_wr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int calc_len_w(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// Next burst start address inside a wrapping region; a burst is never allowed
// to start where a full-length burst would run past the region end.
module sdram_wr_addr_gen #(
    parameter int ADDR_W    = 24,
    parameter int LEN_W     = 4,
    parameter int BURST_LEN = 8,
    parameter int ADDR_MIN  = 0,
    parameter int ADDR_MAX  = 2**24-1
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] next_addr
);

    localparam logic [ADDR_W+1:0] MAX_EXT = (ADDR_W+2)'(ADDR_MAX);
    localparam logic [ADDR_W-1:0] MIN_A   = ADDR_W'(ADDR_MIN);

    logic [ADDR_W:0]   sum;
    logic [ADDR_W+1:0] last_word;

    always_comb begin
        sum       = {1'b0, addr} + (ADDR_W+1)'(len);
        last_word = {1'b0, sum} + (ADDR_W+2)'(BURST_LEN - 1);
        next_addr = (last_word > MAX_EXT) ? MIN_A : sum[ADDR_W-1:0];
    end

endmodule

// File: rtl/sdram_wr_burst_sched.sv
// Write-side burst scheduler: pulls buffered words out of the write FIFO and
// streams them into the SDRAM controller one burst at a time.
module sdram_wr_burst_sched
    import sdram_wr_sched_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 128,
    parameter int ADDR_W    = 24,
    parameter int BURST_LEN = 8,
    parameter int ADDR_MIN  = 0,
    parameter int ADDR_MAX  = 2**24-1
) (
    input  logic                                 sys_clk,
    input  logic                                 sys_rst_n,
    input  logic                                 enable,
    input  logic                                 flush,
    input  logic                                 fifo_empty,
    input  logic [CNT_W-1:0]                     fifo_data_num,
    output logic                                 rd_en,
    input  logic [DATA_W-1:0]                    rd_data,
    output logic                                 sdram_wr_req,
    input  logic                                 sdram_wr_ack,
    output logic [ADDR_W-1:0]                    sdram_wr_addr,
    output logic [calc_len_w(BURST_LEN)-1:0]     sdram_wr_len,
    input  logic                                 sdram_wr_data_req,
    output logic [DATA_W-1:0]                    sdram_wr_data,
    output logic                                 busy,
    output logic                                 burst_done,
    output logic                                 underrun_err
);

    localparam int LEN_W = calc_len_w(BURST_LEN);

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   beat_cnt;
    logic [ADDR_W-1:0]  next_addr;
    logic               vld_p1;
    logic               start_full, start_flush;
    logic               beat_take, last_beat;

    sdram_wr_addr_gen #(
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W),
        .BURST_LEN(BURST_LEN),
        .ADDR_MIN (ADDR_MIN),
        .ADDR_MAX (ADDR_MAX)
    ) u_addr_gen (
        .addr     (sdram_wr_addr),
        .len      (sdram_wr_len),
        .next_addr(next_addr)
    );

    always_comb begin
        start_full  = enable && (fifo_data_num >= CNT_W'(BURST_LEN));
        start_flush = enable && flush && !fifo_empty;
        beat_take   = (state == WRITE) && sdram_wr_data_req && (beat_cnt < sdram_wr_len);
        last_beat   = beat_take && (beat_cnt == sdram_wr_len - LEN_W'(1));
        // An empty FIFO still consumes a beat so the controller's burst closes.
        rd_en       = beat_take && !fifo_empty;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_full || start_flush) state_nxt = REQ;
            REQ:     if (sdram_wr_ack) state_nxt = WRITE;
            WRITE:   if (last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state         <= IDLE;
            sdram_wr_len  <= '0;
            beat_cnt      <= '0;
            sdram_wr_addr <= ADDR_W'(ADDR_MIN);
            vld_p1        <= 1'b0;
            underrun_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (start_full)
                    sdram_wr_len <= LEN_W'(BURST_LEN);
                else if (start_flush)
                    sdram_wr_len <= fifo_data_num[LEN_W-1:0];
            end
            if (state == REQ && sdram_wr_ack)
                beat_cnt <= '0;
            else if (beat_take)
                beat_cnt <= beat_cnt + LEN_W'(1);
            if (last_beat)
                sdram_wr_addr <= next_addr;
            // ---- stage p1: FIFO output for the beat popped last cycle ----
            vld_p1 <= rd_en;
            if (beat_take && fifo_empty)
                underrun_err <= 1'b1;
        end
    end

    assign sdram_wr_req  = (state == REQ);
    assign busy          = (state != IDLE);
    assign burst_done    = (state == DONE);
    assign sdram_wr_data = vld_p1 ? rd_data : '0;

endmodule

// File: tb/tb_sdram_wr_burst_sched.sv
// Directed bench for sdram_wr_burst_sched: full bursts, excess data requests,
// underrun, address wrap in a 32-word region, flush bursts and mid-burst reset.
module tb_sdram_wr_burst_sched;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         flush = 1'b0;
    logic         fifo_empty = 1'b1;
    logic [127:0] fifo_data_num = '0;
    logic         rd_en;
    logic [15:0]  rd_data = 16'h0;
    logic         sdram_wr_req;
    logic         sdram_wr_ack = 1'b0;
    logic [23:0]  sdram_wr_addr;
    logic [3:0]   sdram_wr_len;
    logic         sdram_wr_data_req = 1'b0;
    logic [15:0]  sdram_wr_data;
    logic         busy;
    logic         burst_done;
    logic         underrun_err;

    int passed = 0;
    int total  = 0;
    int pop_cnt = 0;
    logic [15:0] fifo_word = 16'hA000;
    logic [15:0] exp_word  = 16'hA000;

    always #5 sys_clk = ~sys_clk;

    sdram_wr_burst_sched #(
        .DATA_W(16), .CNT_W(128), .ADDR_W(24), .BURST_LEN(8),
        .ADDR_MIN(0), .ADDR_MAX(31)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .enable           (enable),
        .flush            (flush),
        .fifo_empty       (fifo_empty),
        .fifo_data_num    (fifo_data_num),
        .rd_en            (rd_en),
        .rd_data          (rd_data),
        .sdram_wr_req     (sdram_wr_req),
        .sdram_wr_ack     (sdram_wr_ack),
        .sdram_wr_addr    (sdram_wr_addr),
        .sdram_wr_len     (sdram_wr_len),
        .sdram_wr_data_req(sdram_wr_data_req),
        .sdram_wr_data    (sdram_wr_data),
        .busy             (busy),
        .burst_done       (burst_done),
        .underrun_err     (underrun_err)
    );

    // FIFO read port: word appears one cycle after the pop.
    always @(posedge sys_clk) begin
        if (rd_en) begin
            rd_data   <= fifo_word;
            fifo_word <= fifo_word + 16'd1;
            pop_cnt   <= pop_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic req_handshake(input string tag, input logic [23:0] exp_addr,
                                 input logic [3:0] exp_len);
        int cyc = 0;
        do begin
            @(negedge sys_clk);
            cyc++;
        end while (!sdram_wr_req && cyc < 20);
        check({tag, "_req"}, sdram_wr_req, 1'b1);
        check({tag, "_addr"}, sdram_wr_addr, exp_addr);
        check({tag, "_len"}, sdram_wr_len, exp_len);
        check({tag, "_busy"}, busy, 1'b1);
        repeat (2) @(negedge sys_clk);
        check({tag, "_req_hold"}, sdram_wr_req, 1'b1);
        check({tag, "_addr_hold"}, sdram_wr_addr, exp_addr);
        @(negedge sys_clk);
        sdram_wr_ack = 1'b1;
        @(negedge sys_clk);
        sdram_wr_ack = 1'b0;
        check({tag, "_req_drop"}, sdram_wr_req, 1'b0);
        enable = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic run_burst(input string tag, input logic [23:0] exp_addr, input int len,
                             input int n_req, input int ub, input logic [23:0] exp_next,
                             input logic exp_under);
        logic [15:0] beat_word [16];
        int pops_exp = 0;
        int pop_start;
        enable = 1'b1;
        req_handshake(tag, exp_addr, 4'(len));
        pop_start = pop_cnt;
        for (int i = 0; i <= n_req; i++) begin
            if (i > 0) begin
                @(negedge sys_clk);
                check({tag, "_data"}, sdram_wr_data, beat_word[i-1]);
                if (i == len) begin
                    check({tag, "_done"}, burst_done, 1'b1);
                    check({tag, "_next_addr"}, sdram_wr_addr, exp_next);
                end
                if (ub >= 0 && i == ub + 1)
                    check({tag, "_underrun_set"}, underrun_err, 1'b1);
            end
            if (i < n_req) begin
                sdram_wr_data_req = 1'b1;
                fifo_empty = (i == ub);
                #1;
                check({tag, "_rd_en"}, rd_en, (i < len) && (i != ub));
                if (i < len && i != ub) begin
                    beat_word[i] = exp_word;
                    exp_word = exp_word + 16'd1;
                    pops_exp++;
                end else begin
                    beat_word[i] = 16'h0;
                end
            end
        end
        sdram_wr_data_req = 1'b0;
        fifo_empty = 1'b0;
        @(negedge sys_clk);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_idle_done"}, burst_done, 1'b0);
        check({tag, "_pops"}, pop_cnt - pop_start, pops_exp);
        check({tag, "_underrun"}, underrun_err, exp_under);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        check("rst_busy", busy, 1'b0);
        check("rst_req", sdram_wr_req, 1'b0);
        check("rst_addr", sdram_wr_addr, 24'd0);
        check("rst_len", sdram_wr_len, 4'd0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_done", burst_done, 1'b0);
        check("rst_underrun", underrun_err, 1'b0);
        check("rst_data", sdram_wr_data, 16'h0);
        sys_rst_n = 1'b1;
        fifo_empty = 1'b0;
        fifo_data_num = 128'd8;

        run_burst("b1", 24'd0, 8, 8, -1, 24'd8, 1'b0);
        run_burst("b2_excess", 24'd8, 8, 10, -1, 24'd16, 1'b0);
        run_burst("b3_underrun", 24'd16, 8, 8, 3, 24'd24, 1'b1);
        run_burst("b4_wrap", 24'd24, 8, 8, -1, 24'd0, 1'b1);

        fifo_data_num = 128'd5;
        enable = 1'b1;
        flush  = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("partial_no_req", sdram_wr_req, 1'b0);
        check("partial_no_busy", busy, 1'b0);
        flush = 1'b1;
        run_burst("b5_flush", 24'd0, 5, 5, -1, 24'd5, 1'b1);

        fifo_data_num = 128'd8;
        enable = 1'b1;
        req_handshake("b6", 24'd5, 4'd8);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge sys_clk);
            sdram_wr_data_req = 1'b1;
            if (i == 2) sys_rst_n = 1'b0;
        end
        @(negedge sys_clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", rd_en, 1'b0);
        check("mid_rst_addr", sdram_wr_addr, 24'd0);
        check("mid_rst_req", sdram_wr_req, 1'b0);
        check("mid_rst_len", sdram_wr_len, 4'd0);
        check("mid_rst_underrun", underrun_err, 1'b0);
        sdram_wr_data_req = 1'b0;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
